// File: rtl/banked_transpose_buffer_if.sv
// Row-in / vector-out stream bundle for the banked transpose buffer.
// The slave modport is the buffer's view of the bus; master is the environment's view.
interface banked_transpose_buffer_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_MG     = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_MG*DATA_WIDTH-1:0] in_data;
  logic                         in_mode;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_MG*DATA_WIDTH-1:0] out_data;
  logic                         out_last;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/banked_transpose_buffer.sv
// Ping-pong NUM_MG x NUM_MG matrix buffer with diagonally skewed banks.
// Each frame is read out either transposed (columns) or in passthrough (rows).
module banked_transpose_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_MG     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  banked_transpose_buffer_if.slave  bus,
  output logic [15:0]               frame_cnt
);
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_MG);
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam int unsigned VEC_WIDTH  = NUM_MG * DATA_WIDTH;

  typedef enum logic [1:0] {
    PG_EMPTY,
    PG_FILLING,
    PG_FULL,
    PG_DRAINING
  } page_state_e;

  page_state_e            page_state_q [2];
  page_state_e            page_state_d [2];
  logic                   wr_page_q;
  logic                   rd_page_q;
  logic [ADDR_WIDTH-1:0]  wr_row_q;
  logic [CNT_WIDTH-1:0]   rd_cnt_q;
  logic [1:0]             page_mode_q;

  logic [DATA_WIDTH-1:0]  mem [2][NUM_MG][NUM_MG];
  logic [DATA_WIDTH-1:0]  in_lane [NUM_MG];
  logic [DATA_WIDTH-1:0]  wr_word [NUM_MG];
  logic [VEC_WIDTH-1:0]   rd_vec;
  logic [ADDR_WIDTH-1:0]  rd_k;

  logic        accept;
  logic        wr_last_row;
  page_state_e rd_state;
  logic        rd_issue;
  logic        frame_done;

  // Writer owns EMPTY/FILLING pages, reader owns FULL/DRAINING, so they never share a page.
  assign bus.in_ready = !rst && ((page_state_q[wr_page_q] == PG_EMPTY) ||
                                 (page_state_q[wr_page_q] == PG_FILLING));
  assign accept       = bus.in_valid && bus.in_ready;
  assign wr_last_row  = (wr_row_q == ADDR_WIDTH'(NUM_MG - 1));
  assign rd_state     = page_state_q[rd_page_q];
  assign rd_issue     = ((rd_state == PG_FULL) ||
                         ((rd_state == PG_DRAINING) && (rd_cnt_q < CNT_WIDTH'(NUM_MG)))) &&
                        (!bus.out_valid || bus.out_ready);
  assign frame_done   = bus.out_valid && bus.out_ready && bus.out_last;
  assign rd_k         = rd_cnt_q[ADDR_WIDTH-1:0];

  // Per-page lifecycle: next state
  always_comb begin
    page_state_d = page_state_q;
    for (int p = 0; p < 2; p++) begin
      case (page_state_q[p])
        PG_EMPTY:    if (accept && (wr_page_q == 1'(p))) page_state_d[p] = PG_FILLING;
        PG_FILLING:  if (accept && (wr_page_q == 1'(p)) && wr_last_row) page_state_d[p] = PG_FULL;
        PG_FULL:     if (rd_issue && (rd_page_q == 1'(p))) page_state_d[p] = PG_DRAINING;
        PG_DRAINING: if (frame_done && (rd_page_q == 1'(p))) page_state_d[p] = PG_EMPTY;
        default:     page_state_d[p] = PG_EMPTY;
      endcase
    end
  end

  // Element (r,c) lands in bank (r+c): bank b takes lane (b-r) of the incoming row.
  always_comb begin
    for (int c = 0; c < NUM_MG; c++) begin
      in_lane[c] = bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int b = 0; b < NUM_MG; b++) begin
      wr_word[b] = in_lane[ADDR_WIDTH'(ADDR_WIDTH'(b) - wr_row_q)];
    end
  end

  // Lane i always reads bank (i+k); only the address differs between modes.
  always_comb begin
    rd_vec = '0;
    for (int i = 0; i < NUM_MG; i++) begin
      rd_vec[i*DATA_WIDTH +: DATA_WIDTH] =
        mem[rd_page_q][ADDR_WIDTH'(ADDR_WIDTH'(i) + rd_k)]
           [page_mode_q[rd_page_q] ? ADDR_WIDTH'(i) : rd_k];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int b = 0; b < NUM_MG; b++) begin
        mem[wr_page_q][b][wr_row_q] <= wr_word[b];
      end
    end
  end

  // Control, pointers and the registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      page_state_q  <= '{default: PG_EMPTY};
      wr_page_q     <= 1'b0;
      rd_page_q     <= 1'b0;
      wr_row_q      <= '0;
      rd_cnt_q      <= '0;
      page_mode_q   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
      frame_cnt     <= '0;
    end else begin
      page_state_q <= page_state_d;
      if (accept) begin
        wr_row_q <= wr_row_q + ADDR_WIDTH'(1);
        if (wr_row_q == '0) page_mode_q[wr_page_q] <= bus.in_mode;
        if (wr_last_row)    wr_page_q <= ~wr_page_q;
      end
      if (rd_issue) begin
        rd_cnt_q      <= rd_cnt_q + CNT_WIDTH'(1);
        bus.out_valid <= 1'b1;
        bus.out_data  <= rd_vec;
        bus.out_last  <= (rd_cnt_q == CNT_WIDTH'(NUM_MG - 1));
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
      if (frame_done) begin
        rd_page_q <= ~rd_page_q;
        rd_cnt_q  <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_banked_transpose_buffer.sv
// Bench for banked_transpose_buffer: frame-level reference model plus directed scenarios.
module tb_banked_transpose_buffer;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned VW = DW * N;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame_cnt;

  banked_transpose_buffer_if #(.DATA_WIDTH(DW), .NUM_MG(N)) bus ();

  banked_transpose_buffer #(.DATA_WIDTH(DW), .NUM_MG(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VW-1:0] data;
    logic          last;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  vec_t          exp_q[$];
  vec_t          got_q[$];
  logic [DW-1:0] cur [N][N];
  int            cur_rows = 0;
  logic          cur_mode = 1'b0;
  int            held = 0;
  int            frames_done = 0;
  logic          prev_stall = 1'b0;
  logic [VW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [VW-1:0] row_val(input int f, input int r);
    logic [VW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = DW'((f % 4) * 64 + r * 16 + c);
    return v;
  endfunction

  // Reference: a completed frame yields N vectors, columns if transposed, rows otherwise.
  task automatic emit_frame();
    vec_t v;
    for (int k = 0; k < N; k++) begin
      v.data = '0;
      for (int i = 0; i < N; i++) v.data[i*DW +: DW] = cur_mode ? cur[i][k] : cur[k][i];
      v.last = (k == N - 1);
      exp_q.push_back(v);
    end
  endtask

  // Compare process: sampled mid-cycle, then the model advances by this cycle's handshakes.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      exp_q.delete();
      cur_rows    = 0;
      held        = 0;
      frames_done = 0;
      prev_stall  = 1'b0;
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'(held < 2));
      check("frame_cnt", 32'(frame_cnt), 32'(16'(frames_done)));
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", bus.out_data, prev_data);
        check("hold_last", 32'(bus.out_last), 32'(prev_last));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          check("out_data", bus.out_data, exp_q[0].data);
          check("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
          if (bus.out_ready) begin
            got_q.push_back('{data: bus.out_data, last: bus.out_last});
            if (exp_q[0].last) begin
              held--;
              frames_done++;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (bus.in_valid && bus.in_ready) begin
        if (cur_rows == 0) cur_mode = bus.in_mode;
        for (int c = 0; c < N; c++) cur[cur_rows][c] = bus.in_data[c*DW +: DW];
        cur_rows++;
        if (cur_rows == N) begin
          emit_frame();
          cur_rows = 0;
          held++;
        end
      end
    end
  end

  task automatic drive_row(input logic [VW-1:0] d, input logic m);
    logic ok;
    int   budget;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    budget = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!ok && budget < 300);
    check("row_accept", 32'(ok), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rows(input int f, input logic m0, input logic m_rest, input int n);
    for (int r = 0; r < n; r++) drive_row(row_val(f, r), (r == 0) ? m0 : m_rest);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && b < 500) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_last", 32'(bus.out_last), 32'd0);
    check("reset_out_data", bus.out_data, 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Transpose with an always-ready consumer, including first-vector latency
    got_q.delete();
    send_rows(0, 1'b1, 1'b1, N);
    check("lat_t1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_t2_valid", 32'(bus.out_valid), 32'd1);
    check("lat_t2_data", bus.out_data, 32'h30201000);
    wait_drain();
    check("t1_count", 32'(got_q.size()), 32'd4);
    check("t1_vec0", got_q[0].data, 32'h30201000);
    check("t1_vec1_last", 32'(got_q[1].last), 32'd0);
    check("t1_vec3", got_q[3].data, 32'h33231303);
    check("t1_vec3_last", 32'(got_q[3].last), 32'd1);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Passthrough returns the rows unchanged
    got_q.delete();
    send_rows(1, 1'b0, 1'b0, N);
    wait_drain();
    check("t2_vec0", got_q[0].data, 32'h43424140);
    check("t2_vec2", got_q[2].data, 32'h63626160);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Three frames against a stalled consumer: third waits for a page to free up
    pulse_reset();
    got_q.delete();
    bus.out_ready = 1'b0;
    send_rows(2, 1'b1, 1'b1, N);
    send_rows(3, 1'b1, 1'b1, N);
    check("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
    fork
      send_rows(0, 1'b1, 1'b1, N);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("t3_count", 32'(got_q.size()), 32'd12);
    check("t3_f0_vec0", got_q[0].data, 32'hB0A09080);
    check("t3_f1_vec0", got_q[4].data, 32'hF0E0D0C0);
    check("t3_f2_vec0", got_q[8].data, 32'h30201000);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd3);

    // Consumer ready toggling every cycle
    got_q.delete();
    fork
      send_rows(1, 1'b1, 1'b1, N);
      for (int i = 0; i < 16; i++) begin
        bus.out_ready = (i % 2 == 0);
        @(posedge clk);
        #1;
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    check("t4_count", 32'(got_q.size()), 32'd4);
    check("t4_vec1", got_q[1].data, 32'h71615141);
    check("t4_vec3_last", 32'(got_q[3].last), 32'd1);

    // Reset while one frame drains and the next is partially filled
    send_rows(2, 1'b1, 1'b1, N);
    send_rows(3, 1'b1, 1'b1, 3);
    check("t5_draining", 32'(bus.out_valid), 32'd1);
    pulse_reset();
    @(negedge clk);
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    got_q.delete();
    send_rows(0, 1'b1, 1'b1, N);
    wait_drain();
    check("t5_count", 32'(got_q.size()), 32'd4);
    check("t5_vec0", got_q[0].data, 32'h30201000);
    check("t5_frame_cnt_after", 32'(frame_cnt), 32'd1);

    // Mode only sampled with row 0
    got_q.delete();
    send_rows(1, 1'b1, 1'b0, N);
    wait_drain();
    check("t6_vec0", got_q[0].data, 32'h70605040);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
